cplx_trivrot_pipe: RTL

- Parametrised, pipelined successor to the 32-bit complex bypass/trivial-rotation unit.
- Operates on packed complex samples (real in the upper half, imaginary in the lower half).
- Per sample it optionally swaps the real and imaginary parts, then optionally negates each output part. This implements multiplication by ±1, ±j and conjugation.
- Adds a valid/ready stream handshake, a 2-stage register pipeline, optional saturating negation and a sticky overflow flag. It sits in the FFT butterfly datapath wherever trivial twiddles (W^0, W^N/4) bypass the complex multiplier.

---
 rtl/cplx_pkg.sv | 18 +
 rtl/sgninv_sat.sv | 27 ++
 rtl/cplx_trivrot_pipe.sv | 120 ++++++++++++
 3 files changed

// File: rtl/cplx_pkg.sv
// rtl/cplx_pkg.sv - mode bit indices and named modes for the complex trivial-rotation pipe
// Contents: SEL_* bit positions within TYPESEL, MODE_* full TYPESEL encodings.
package cplx_pkg;

  // TYPESEL bit positions
  localparam int SEL_SWAP = 2;
  localparam int SEL_NEGR = 1;
  localparam int SEL_NEGI = 0;

  // Named TYPESEL encodings: {swap, neg_re, neg_im}
  localparam logic [2:0] MODE_ID    = 3'b000;  // x
  localparam logic [2:0] MODE_CONJ  = 3'b001;  // conj(x)
  localparam logic [2:0] MODE_SWAP  = 3'b100;  // re <-> im
  localparam logic [2:0] MODE_MULJ  = 3'b110;  // x * (+j)
  localparam logic [2:0] MODE_MULNJ = 3'b101;  // x * (-j)
  localparam logic [2:0] MODE_NEG   = 3'b011;  // x * (-1)

endpackage

// File: rtl/sgninv_sat.sv
// rtl/sgninv_sat.sv - combinational W-bit two's complement negation with overflow flag
// Ports:
//   x   in  W  operand
//   y   out W  -x; for x = -2^(W-1): 2^(W-1)-1 when SAT=1, x itself when SAT=0
//   ovf out 1  x = -2^(W-1) (the one value with no representable negation)
module sgninv_sat #(
  parameter int W   = 16,
  parameter bit SAT = 1'b1
) (
  input  logic [W-1:0] x,
  output logic [W-1:0] y,
  output logic         ovf
);

  localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] MAX_VAL = {1'b0, {(W-1){1'b1}}};

  always_comb begin
    ovf = (x == MIN_VAL);
    if (ovf) begin
      y = SAT ? MAX_VAL : x;
    end else begin
      y = ~x + 1'b1;
    end
  end

endmodule

// File: rtl/cplx_trivrot_pipe.sv
// rtl/cplx_trivrot_pipe.sv - 2-stage valid/ready pipe multiplying complex samples by +-1, +-j or conjugating
// Ports:
//   CLK       in  1    clock, rising edge
//   RST       in  1    asynchronous active-high reset
//   IN_VALID  in  1    input sample valid
//   IN_READY  out 1    sample accepted this cycle when IN_VALID
//   A         in  2W   input sample {real, imag}
//   TYPESEL   in  3    {swap, neg real out, neg imag out}, captured with A
//   OUT_VALID out 1    R holds a valid sample
//   OUT_READY in  1    downstream accepts R
//   R         out 2W   output sample {real, imag}
//   OVF       out 1    sticky: a negation of -2^(W-1) occurred
//   OVF_CLR   in  1    synchronous clear of OVF (a coincident set wins)
module cplx_trivrot_pipe #(
  parameter int W   = 16,
  parameter bit SAT = 1'b1
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           IN_VALID,
  output logic           IN_READY,
  input  logic [2*W-1:0] A,
  input  logic [2:0]     TYPESEL,
  output logic           OUT_VALID,
  input  logic           OUT_READY,
  output logic [2*W-1:0] R,
  output logic           OVF,
  input  logic           OVF_CLR
);

  import cplx_pkg::*;

  logic         v1, v2;
  logic         en1, en2;
  logic [W-1:0] re_in, im_in;
  logic [W-1:0] p_d, q_d;
  logic [W-1:0] p_q, q_q;
  logic         negr_q, negi_q;
  logic [W-1:0] neg_p, neg_q;
  logic         ovf_p, ovf_q;
  logic [W-1:0] re_out, im_out;
  logic         ovf_evt;

  // A stage may advance when it is empty or its successor advances,
  // giving full throughput without bubbles.
  assign en2       = !v2 || OUT_READY;
  assign en1       = !v1 || en2;
  assign IN_READY  = en1;
  assign OUT_VALID = v2;

  // S1: optional real/imag swap
  assign re_in = A[2*W-1:W];
  assign im_in = A[W-1:0];
  assign p_d   = TYPESEL[SEL_SWAP] ? im_in : re_in;
  assign q_d   = TYPESEL[SEL_SWAP] ? re_in : im_in;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      v1     <= 1'b0;
      p_q    <= '0;
      q_q    <= '0;
      negr_q <= 1'b0;
      negi_q <= 1'b0;
    end else if (en1) begin
      v1 <= IN_VALID;
      // Data only loads with a real sample so X on idle inputs never
      // reaches state.
      if (IN_VALID) begin
        p_q    <= p_d;
        q_q    <= q_d;
        negr_q <= TYPESEL[SEL_NEGR];
        negi_q <= TYPESEL[SEL_NEGI];
      end
    end
  end

  // S2: optional negation of each part
  sgninv_sat #(.W(W), .SAT(SAT)) u_neg_re (
    .x   (p_q),
    .y   (neg_p),
    .ovf (ovf_p)
  );

  sgninv_sat #(.W(W), .SAT(SAT)) u_neg_im (
    .x   (q_q),
    .y   (neg_q),
    .ovf (ovf_q)
  );

  assign re_out = negr_q ? neg_p : p_q;
  assign im_out = negi_q ? neg_q : q_q;

  // Overflow only counts for a negation actually applied to a valid sample
  // entering S2.
  assign ovf_evt = en2 && v1 && ((negr_q && ovf_p) || (negi_q && ovf_q));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      v2 <= 1'b0;
      R  <= '0;
    end else if (en2) begin
      v2 <= v1;
      // R keeps the last sample when a bubble passes through.
      if (v1) begin
        R <= {re_out, im_out};
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      OVF <= 1'b0;
    end else if (ovf_evt) begin
      OVF <= 1'b1;
    end else if (OVF_CLR) begin
      OVF <= 1'b0;
    end
  end

endmodule
